segment_collision_scanner: RTL and testbench

- Parametrised successor to the toolpath collision checker.
- Accepts 3-D line segments one at a time over a valid/ready handshake and stores them in an internal segment RAM.
- Scans each new segment against every stored segment, one comparison per cycle, using the orientation/on-segment test, and reports each colliding pair.
- Sits between the G-code segment parser and the print-abort/report logic.

---
 rtl/seg_pkg.sv | 35 +++
 rtl/segment_collision_scanner_if.sv | 33 +++
 rtl/seg_intersect.sv | 65 ++++++
 rtl/segment_collision_scanner.sv | 133 +++++++++++++
 tb/tb_segment_collision_scanner.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared types and default sizing for the segment collision scanner.
package seg_pkg;

    localparam int SEG_COORD_W = 8;
    localparam int SEG_DEPTH   = 128;

    // Index width for a table of 'depth' entries (never narrower than 1 bit).
    function automatic int seg_id_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int SEG_ID_W = seg_id_w(SEG_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ORI_COL = 2'd0,
        ORI_POS = 2'd1,
        ORI_NEG = 2'd2
    } ori_t;

    typedef struct packed {
        logic [SEG_COORD_W-1:0] x1;
        logic [SEG_COORD_W-1:0] y1;
        logic [SEG_COORD_W-1:0] z1;
        logic [SEG_COORD_W-1:0] x2;
        logic [SEG_COORD_W-1:0] y2;
        logic [SEG_COORD_W-1:0] z2;
    } seg_t;

endpackage

// File: rtl/segment_collision_scanner_if.sv
// Segment input handshake plus collision report bus.
interface segment_collision_scanner_if
    import seg_pkg::*;
#(
    parameter int COORD_W = SEG_COORD_W,
    parameter int ID_W    = SEG_ID_W
);
    logic               in_val;
    logic               in_rdy;
    logic               clear;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] z1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y2;
    logic [COORD_W-1:0] z2;
    logic               out_val;
    logic [ID_W-1:0]    lineID;
    logic [ID_W-1:0]    new_id;
    logic               done;
    logic               full;
    logic [15:0]        hit_count;

    modport master (
        output in_val, clear, x1, y1, z1, x2, y2, z2,
        input  in_rdy, out_val, lineID, new_id, done, full, hit_count
    );

    modport slave (
        input  in_val, clear, x1, y1, z1, x2, y2, z2,
        output in_rdy, out_val, lineID, new_id, done, full, hit_count
    );
endinterface

// File: rtl/seg_intersect.sv
// Combinational 2-D segment intersection test with optional same-plane gate.
module seg_intersect
    import seg_pkg::*;
#(
    parameter int COORD_W = SEG_COORD_W,
    parameter bit ZMODE   = 1'b0
) (
    input  seg_t a,
    input  seg_t b,
    output logic hit
);
    // Wide enough that the cross-product difference never overflows.
    localparam int OW = 2 * COORD_W + 3;

    // Turn direction of a->b->c: collinear, positive or negative.
    function automatic ori_t orient(input logic [COORD_W-1:0] ax, ay, bx, by, cx, cy);
        logic signed [OW-1:0] dy1, dx1, dx2, dy2, v;
        dy1 = OW'(by) - OW'(ay);
        dx1 = OW'(bx) - OW'(ax);
        dx2 = OW'(cx) - OW'(bx);
        dy2 = OW'(cy) - OW'(by);
        v   = (dy1 * dx2) - (dx1 * dy2);
        if (v == {OW{1'b0}}) begin
            return ORI_COL;
        end else if (!v[OW-1]) begin
            return ORI_POS;
        end else begin
            return ORI_NEG;
        end
    endfunction

    // Point q lies inside the inclusive bounding box spanned by p and r.
    function automatic logic in_box(input logic [COORD_W-1:0] px, py, qx, qy, rx, ry);
        logic [COORD_W-1:0] lox, hix, loy, hiy;
        lox = (px < rx) ? px : rx;
        hix = (px < rx) ? rx : px;
        loy = (py < ry) ? py : ry;
        hiy = (py < ry) ? ry : py;
        return (qx >= lox) && (qx <= hix) && (qy >= loy) && (qy <= hiy);
    endfunction

    ori_t o1_s, o2_s, o3_s, o4_s;
    logic xy_hit_s;
    logic z_ok_s;

    // Orientation test in the XY projection, then the optional plane gate.
    always_comb begin
        o1_s = orient(a.x1, a.y1, a.x2, a.y2, b.x1, b.y1);
        o2_s = orient(a.x1, a.y1, a.x2, a.y2, b.x2, b.y2);
        o3_s = orient(b.x1, b.y1, b.x2, b.y2, a.x1, a.y1);
        o4_s = orient(b.x1, b.y1, b.x2, b.y2, a.x2, a.y2);
        xy_hit_s = ((o1_s != o2_s) && (o3_s != o4_s))
                || ((o1_s == ORI_COL) && in_box(a.x1, a.y1, b.x1, b.y1, a.x2, a.y2))
                || ((o2_s == ORI_COL) && in_box(a.x1, a.y1, b.x2, b.y2, a.x2, a.y2))
                || ((o3_s == ORI_COL) && in_box(b.x1, b.y1, a.x1, a.y1, b.x2, b.y2))
                || ((o4_s == ORI_COL) && in_box(b.x1, b.y1, a.x2, a.y2, b.x2, b.y2));
        z_ok_s = (a.z1 == a.z2) && (b.z1 == b.z2) && (a.z1 == b.z1);
        if (ZMODE) begin
            hit = xy_hit_s && z_ok_s;
        end else begin
            hit = xy_hit_s;
        end
    end

endmodule

// File: rtl/segment_collision_scanner.sv
// Stores incoming segments and scans each new one against all stored ones.
module segment_collision_scanner
    import seg_pkg::*;
#(
    parameter int COORD_W  = SEG_COORD_W,
    parameter int DEPTH    = SEG_DEPTH,
    parameter bit SKIP_ADJ = 1'b1,
    parameter bit ZMODE    = 1'b0
) (
    input logic                        clk,
    input logic                        reset,
    segment_collision_scanner_if.slave bus
);
    localparam int ID_W  = seg_id_w(DEPTH);
    localparam int CNT_W = seg_id_w(DEPTH + 1);

    seg_t             mem [DEPTH];
    seg_t             cap_r;
    seg_t             seg_in_s;
    seg_t             ram_rd_s;
    state_t           state_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] last_idx_s;
    logic [ID_W-1:0]  ptr_r;
    logic             pair_hit_s;
    logic             in_rdy_r;
    logic             out_val_r;
    logic [ID_W-1:0]  line_id_r;
    logic [ID_W-1:0]  new_id_r;
    logic             done_r;
    logic             full_r;
    logic [15:0]      hit_count_r;

    assign seg_in_s = '{x1: bus.x1, y1: bus.y1, z1: bus.z1,
                        x2: bus.x2, y2: bus.y2, z2: bus.z2};
    assign ram_rd_s = mem[ptr_r];
    // The predecessor is skipped by stopping one entry early.
    assign last_idx_s = count_r - CNT_W'(1) - CNT_W'(SKIP_ADJ);

    seg_intersect #(.COORD_W(COORD_W), .ZMODE(ZMODE)) u_intersect (
        .a   (cap_r),
        .b   (ram_rd_s),
        .hit (pair_hit_s)
    );

    // Segment store: the captured segment lands in the next free slot on commit.
    always_ff @(posedge clk) begin
        if (state_r == COMMIT) begin
            mem[count_r[ID_W-1:0]] <= cap_r;
        end
    end

    // Control FSM with all externally visible registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cap_r       <= '0;
            count_r     <= '0;
            ptr_r       <= '0;
            in_rdy_r    <= 1'b0;
            out_val_r   <= 1'b0;
            line_id_r   <= '0;
            new_id_r    <= '0;
            done_r      <= 1'b0;
            full_r      <= 1'b0;
            hit_count_r <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    out_val_r <= 1'b0;
                    done_r    <= 1'b0;
                    if (bus.clear) begin
                        count_r     <= '0;
                        hit_count_r <= 16'd0;
                        full_r      <= 1'b0;
                        in_rdy_r    <= 1'b1;
                    end else if (bus.in_val && in_rdy_r) begin
                        cap_r    <= seg_in_s;
                        new_id_r <= count_r[ID_W-1:0];
                        ptr_r    <= '0;
                        in_rdy_r <= 1'b0;
                        if (count_r <= CNT_W'(SKIP_ADJ)) begin
                            state_r <= COMMIT;
                        end else begin
                            state_r <= SCAN;
                        end
                    end else begin
                        in_rdy_r <= !full_r;
                    end
                end
                SCAN: begin
                    in_rdy_r  <= 1'b0;
                    done_r    <= 1'b0;
                    out_val_r <= pair_hit_s;
                    if (pair_hit_s) begin
                        line_id_r <= ptr_r;
                        if (hit_count_r != 16'hFFFF) begin
                            hit_count_r <= hit_count_r + 16'd1;
                        end
                    end
                    if (CNT_W'(ptr_r) == last_idx_s) begin
                        state_r <= COMMIT;
                    end else begin
                        ptr_r <= ptr_r + ID_W'(1);
                    end
                end
                COMMIT: begin
                    out_val_r <= 1'b0;
                    done_r    <= 1'b1;
                    count_r   <= count_r + CNT_W'(1);
                    full_r    <= (count_r + CNT_W'(1)) == CNT_W'(DEPTH);
                    in_rdy_r  <= (count_r + CNT_W'(1)) != CNT_W'(DEPTH);
                    state_r   <= IDLE;
                end
                default: begin
                    out_val_r <= 1'b0;
                    done_r    <= 1'b0;
                    in_rdy_r  <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_rdy    = in_rdy_r;
    assign bus.out_val   = out_val_r;
    assign bus.lineID    = line_id_r;
    assign bus.new_id    = new_id_r;
    assign bus.done      = done_r;
    assign bus.full      = full_r;
    assign bus.hit_count = hit_count_r;

endmodule

// File: tb/tb_segment_collision_scanner.sv
// Self-checking bench: four scanner instances covering SKIP_ADJ, ZMODE and DEPTH variants.
module tb_segment_collision_scanner;
    import seg_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]  in_val_b;
    logic [3:0]  clear_b;
    seg_t        seg_b [4];
    logic [3:0]  in_rdy_o;
    logic [3:0]  out_val_o;
    logic [3:0]  done_o;
    logic [3:0]  full_o;
    logic [7:0]  line_o [4];
    logic [7:0]  new_o [4];
    logic [15:0] hit_o [4];

    // Scoreboard: expected {new_id, lineID} per instance, in report order.
    logic [15:0] exp_q [4][$];
    int checks = 0;
    int errors = 0;

    // dut0: SKIP_ADJ=0 ZMODE=0 DEPTH=8; dut1: SKIP_ADJ=1 DEPTH=8;
    // dut2: SKIP_ADJ=0 ZMODE=1 DEPTH=8; dut3: SKIP_ADJ=1 DEPTH=4.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int DP = (g == 3) ? 4 : 8;
        localparam bit SK = (g == 1 || g == 3) ? 1'b1 : 1'b0;
        localparam bit ZM = (g == 2) ? 1'b1 : 1'b0;
        localparam int IW = seg_id_w(DP);

        segment_collision_scanner_if #(.COORD_W(SEG_COORD_W), .ID_W(IW)) bus ();

        segment_collision_scanner #(
            .COORD_W(SEG_COORD_W), .DEPTH(DP), .SKIP_ADJ(SK), .ZMODE(ZM)
        ) dut (
            .clk   (clk),
            .reset (rst),
            .bus   (bus)
        );

        assign bus.in_val = in_val_b[g];
        assign bus.clear  = clear_b[g];
        assign bus.x1 = seg_b[g].x1;
        assign bus.y1 = seg_b[g].y1;
        assign bus.z1 = seg_b[g].z1;
        assign bus.x2 = seg_b[g].x2;
        assign bus.y2 = seg_b[g].y2;
        assign bus.z2 = seg_b[g].z2;
        assign in_rdy_o[g]  = bus.in_rdy;
        assign out_val_o[g] = bus.out_val;
        assign done_o[g]    = bus.done;
        assign full_o[g]    = bus.full;
        assign line_o[g]    = 8'(bus.lineID);
        assign new_o[g]     = 8'(bus.new_id);
        assign hit_o[g]     = bus.hit_count;
    end

    function automatic seg_t mk(input int ax, ay, az, bx, by, bz);
        seg_t s;
        s.x1 = SEG_COORD_W'(ax); s.y1 = SEG_COORD_W'(ay); s.z1 = SEG_COORD_W'(az);
        s.x2 = SEG_COORD_W'(bx); s.y2 = SEG_COORD_W'(by); s.z2 = SEG_COORD_W'(bz);
        return s;
    endfunction

    // Every out_val pulse must match the oldest expected collision of that instance.
    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (out_val_o[g] === 1'b1) begin
                checks++;
                if (exp_q[g].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_hit dut%0d: got new_id=%0d lineID=%0d, expected no hit",
                             g, new_o[g], line_o[g]);
                end else begin
                    logic [15:0] e;
                    e = exp_q[g].pop_front();
                    if ({new_o[g], line_o[g]} !== e) begin
                        errors++;
                        $display("FAIL hit_ids dut%0d: got new_id=%0d lineID=%0d, expected new_id=%0d lineID=%0d",
                                 g, new_o[g], line_o[g], e[15:8], e[7:0]);
                    end
                end
            end
        end
    end

    // Offer one segment; report accept-to-done latency, new_id and unmatched expected hits.
    task automatic send_seg(input int g, input seg_t s, input bit hold,
                            output int lat, output int nid, output int miss);
        int guard;
        seg_t junk;
        guard = 0;
        @(negedge clk);
        while (in_rdy_o[g] !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        seg_b[g] = s;
        in_val_b[g] = 1'b1;
        @(negedge clk);
        lat = 1;
        if (hold) begin
            junk = ~s;
            seg_b[g] = junk;
        end else begin
            in_val_b[g] = 1'b0;
        end
        while (done_o[g] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        in_val_b[g] = 1'b0;
        nid = int'(new_o[g]);
        miss = exp_q[g].size();
        exp_q[g].delete();
    endtask

    // Clear with in_val raised in the same cycle; count any done seen afterwards.
    task automatic do_clear(input int g, output int saw_done);
        @(negedge clk);
        clear_b[g] = 1'b1;
        in_val_b[g] = 1'b1;
        seg_b[g] = mk(1, 1, 0, 2, 2, 0);
        @(negedge clk);
        clear_b[g] = 1'b0;
        in_val_b[g] = 1'b0;
        saw_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (done_o[g] === 1'b1) saw_done++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            checks++;
            if ({in_rdy_o[g], out_val_o[g], done_o[g], full_o[g], hit_o[g], line_o[g], new_o[g]} !== 36'd0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got rdy=%b val=%b done=%b full=%b hits=%0d, expected all 0",
                         g, in_rdy_o[g], out_val_o[g], done_o[g], full_o[g], hit_o[g]);
            end
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_rdy_o !== 4'b1111) begin
            errors++;
            $display("FAIL ready_after_reset: got %b expected 1111", in_rdy_o);
        end
    endtask

    task automatic test_cross();
        int lat, nid, miss;
        send_seg(0, mk(0, 0, 5, 10, 10, 5), 1'b0, lat, nid, miss);
        checks++;
        if (lat != 2 || nid != 0) begin
            errors++;
            $display("FAIL cross_seg0: got lat=%0d id=%0d expected lat=2 id=0", lat, nid);
        end
        exp_q[0].push_back({8'd1, 8'd0});
        send_seg(0, mk(0, 10, 5, 10, 0, 5), 1'b1, lat, nid, miss);
        checks++;
        if (lat != 3 || nid != 1 || miss != 0) begin
            errors++;
            $display("FAIL cross_seg1: got lat=%0d id=%0d missing=%0d expected lat=3 id=1 missing=0", lat, nid, miss);
        end
        checks++;
        if (hit_o[0] !== 16'd1) begin
            errors++;
            $display("FAIL cross_hit_count: got %0d expected 1", hit_o[0]);
        end
    endtask

    task automatic test_parallel();
        int lat, nid, miss, sd;
        do_clear(0, sd);
        checks++;
        if (sd != 0 || full_o[0] !== 1'b0 || hit_o[0] !== 16'd0) begin
            errors++;
            $display("FAIL clear_dut0: got done_seen=%0d full=%b hits=%0d expected 0 0 0", sd, full_o[0], hit_o[0]);
        end
        send_seg(0, mk(0, 0, 0, 10, 0, 0), 1'b0, lat, nid, miss);
        send_seg(0, mk(0, 5, 0, 10, 5, 0), 1'b0, lat, nid, miss);
        checks++;
        if (lat != 3 || nid != 1) begin
            errors++;
            $display("FAIL parallel_seg1: got lat=%0d id=%0d expected lat=3 id=1", lat, nid);
        end
        send_seg(0, mk(200, 200, 0, 210, 210, 0), 1'b0, lat, nid, miss);
        checks++;
        if (lat != 4 || nid != 2 || hit_o[0] !== 16'd0) begin
            errors++;
            $display("FAIL parallel_count: got lat=%0d id=%0d hits=%0d expected lat=4 id=2 hits=0", lat, nid, hit_o[0]);
        end
    endtask

    task automatic test_collinear();
        int lat, nid, miss, sd;
        do_clear(0, sd);
        send_seg(0, mk(0, 0, 0, 10, 0, 0), 1'b0, lat, nid, miss);
        exp_q[0].push_back({8'd1, 8'd0});
        send_seg(0, mk(5, 0, 0, 20, 0, 0), 1'b0, lat, nid, miss);
        checks++;
        if (lat != 3 || miss != 0 || hit_o[0] !== 16'd1) begin
            errors++;
            $display("FAIL collinear_noskip: got lat=%0d missing=%0d hits=%0d expected 3 0 1", lat, miss, hit_o[0]);
        end
        send_seg(1, mk(0, 0, 0, 10, 0, 0), 1'b0, lat, nid, miss);
        send_seg(1, mk(5, 0, 0, 20, 0, 0), 1'b0, lat, nid, miss);
        checks++;
        if (lat != 2 || nid != 1 || hit_o[1] !== 16'd0) begin
            errors++;
            $display("FAIL collinear_skip: got lat=%0d id=%0d hits=%0d expected 2 1 0", lat, nid, hit_o[1]);
        end
    endtask

    task automatic test_multi_hit();
        int lat, nid, miss, sd;
        int exp_lat [4] = '{2, 2, 3, 4};
        do_clear(1, sd);
        for (int i = 0; i < 4; i++) begin
            send_seg(1, mk(0, 2 * (i + 1), 0, 10, 2 * (i + 1), 0), 1'b0, lat, nid, miss);
            checks++;
            if (lat != exp_lat[i] || nid != i) begin
                errors++;
                $display("FAIL multi_store%0d: got lat=%0d id=%0d expected lat=%0d id=%0d", i, lat, nid, exp_lat[i], i);
            end
        end
        for (int i = 0; i < 3; i++) exp_q[1].push_back({8'd4, 8'(i)});
        send_seg(1, mk(5, 0, 0, 5, 10, 0), 1'b0, lat, nid, miss);
        checks++;
        if (lat != 5 || nid != 4 || miss != 0 || hit_o[1] !== 16'd3) begin
            errors++;
            $display("FAIL multi_hit: got lat=%0d id=%0d missing=%0d hits=%0d expected 5 4 0 3", lat, nid, miss, hit_o[1]);
        end
    endtask

    task automatic test_zmode();
        int lat, nid, miss, sd;
        send_seg(2, mk(0, 0, 5, 10, 10, 5), 1'b0, lat, nid, miss);
        send_seg(2, mk(0, 10, 6, 10, 0, 6), 1'b0, lat, nid, miss);
        checks++;
        if (lat != 3 || hit_o[2] !== 16'd0) begin
            errors++;
            $display("FAIL zmode_mismatch: got lat=%0d hits=%0d expected 3 0", lat, hit_o[2]);
        end
        do_clear(2, sd);
        send_seg(2, mk(0, 0, 5, 10, 10, 5), 1'b0, lat, nid, miss);
        exp_q[2].push_back({8'd1, 8'd0});
        send_seg(2, mk(0, 10, 5, 10, 0, 5), 1'b0, lat, nid, miss);
        checks++;
        if (lat != 3 || miss != 0 || hit_o[2] !== 16'd1) begin
            errors++;
            $display("FAIL zmode_match: got lat=%0d missing=%0d hits=%0d expected 3 0 1", lat, miss, hit_o[2]);
        end
    endtask

    task automatic test_full_clear();
        int lat, nid, miss, sd, dn, rd;
        int exp_lat [4] = '{2, 2, 3, 4};
        for (int i = 0; i < 4; i++) begin
            send_seg(3, mk(0, 20 * i, 0, 10, 20 * i, 0), 1'b0, lat, nid, miss);
            checks++;
            if (lat != exp_lat[i] || nid != i) begin
                errors++;
                $display("FAIL fill%0d: got lat=%0d id=%0d expected lat=%0d id=%0d", i, lat, nid, exp_lat[i], i);
            end
        end
        checks++;
        if (full_o[3] !== 1'b1 || in_rdy_o[3] !== 1'b0) begin
            errors++;
            $display("FAIL full_flag: got full=%b rdy=%b expected full=1 rdy=0", full_o[3], in_rdy_o[3]);
        end
        seg_b[3] = mk(100, 100, 0, 110, 110, 0);
        in_val_b[3] = 1'b1;
        dn = 0;
        rd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_o[3] === 1'b1) dn++;
            if (in_rdy_o[3] === 1'b1) rd++;
        end
        in_val_b[3] = 1'b0;
        checks++;
        if (dn != 0 || rd != 0) begin
            errors++;
            $display("FAIL full_reject: got done_seen=%0d rdy_seen=%0d expected 0 0", dn, rd);
        end
        do_clear(3, sd);
        checks++;
        if (full_o[3] !== 1'b0 || in_rdy_o[3] !== 1'b1 || sd != 0) begin
            errors++;
            $display("FAIL clear_full: got full=%b rdy=%b done_seen=%0d expected 0 1 0", full_o[3], in_rdy_o[3], sd);
        end
        send_seg(3, mk(0, 0, 0, 10, 0, 0), 1'b0, lat, nid, miss);
        checks++;
        if (lat != 2 || nid != 0) begin
            errors++;
            $display("FAIL clear_count: got lat=%0d id=%0d expected lat=2 id=0", lat, nid);
        end
    endtask

    task automatic test_reset_mid_scan();
        int lat, nid, miss, dn;
        send_seg(3, mk(0, 20, 0, 10, 20, 0), 1'b0, lat, nid, miss);
        send_seg(3, mk(0, 40, 0, 10, 40, 0), 1'b0, lat, nid, miss);
        @(negedge clk);
        seg_b[3] = mk(5, 0, 0, 5, 50, 0);
        in_val_b[3] = 1'b1;
        @(negedge clk);
        in_val_b[3] = 1'b0;
        checks++;
        if (new_o[3] !== 8'd3) begin
            errors++;
            $display("FAIL scan_accept: got new_id=%0d expected 3", new_o[3]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({in_rdy_o[3], out_val_o[3], done_o[3], full_o[3], hit_o[3], line_o[3], new_o[3]} !== 36'd0) begin
            errors++;
            $display("FAIL reset_mid_scan: got rdy=%b val=%b done=%b new_id=%0d expected all 0",
                     in_rdy_o[3], out_val_o[3], done_o[3], new_o[3]);
        end
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_o[3] === 1'b1) dn++;
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL done_after_abort: got %0d done pulses expected 0", dn);
        end
    endtask

    initial begin
        in_val_b = 4'b0000;
        clear_b  = 4'b0000;
        for (int i = 0; i < 4; i++) seg_b[i] = '0;
        test_reset();
        test_cross();
        test_parallel();
        test_collinear();
        test_multi_hit();
        test_zmode();
        test_full_clear();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
